// File: rtl/spi_reg_sched.sv
// Purpose: queues decoded SPI frames and replays them in order onto the register bank port.
// Latency: FIFO head to reg_wr_en/reg_rd_en is 3 cycles; writes into the slot window wait for frame_sync.
// Backpressure: none toward the SPI side; a frame arriving on a full FIFO is dropped and fifo_ovf is set.
module spi_reg_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DEFER_LO   = 16'h0040,
  parameter logic [15:0] DEFER_HI   = 16'h006F,
  parameter int          RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd_flag,
  input  logic [63:0] rxd_data,
  input  logic        frame_sync,
  input  logic        clear_err,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_rd_valid,
  output logic        txd_load,
  output logic [63:0] txd_data,
  output logic        busy,
  output logic        fifo_ovf,
  output logic        cmd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;

  typedef enum logic [2:0] {IDLE, DECODE, WR, WAIT_SYNC, RD, RD_WAIT, RESP} state_t;

  state_t state, state_nxt;

  // FIFO entries keep only cmd/addr/data; the reserved byte is never used downstream.
  logic [55:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, drop;
  logic          rsvd_unused;

  logic [55:0]   cmd_q;
  logic [7:0]    cmd_op;
  logic [15:0]   cmd_addr;
  logic [31:0]   cmd_data;
  logic          deferred;
  logic [CW-1:0] tcnt;
  logic          invalid_cmd, timeout;

  assign rsvd_unused = ^rxd_data[39:32];

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = rxd_flag && (!full || pop);
  assign drop  = rxd_flag && full && !pop;

  assign cmd_op   = cmd_q[55:48];
  assign cmd_addr = cmd_q[47:32];
  assign cmd_data = cmd_q[31:0];
  assign deferred = (cmd_addr >= DEFER_LO) && (cmd_addr <= DEFER_HI);

  assign reg_wr_en = (state == WR);
  assign reg_rd_en = (state == RD);
  assign txd_load  = (state == RESP);
  assign busy      = !empty || (state != IDLE);

  // Frame storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {rxd_data[63:40], rxd_data[31:0]};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register and the command currently being executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cmd_q <= fifo_mem[rd_ptr];
    end
  end

  // Sequencing: one command at a time, strictly in FIFO order.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    invalid_cmd = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (cmd_op == CMD_WR)      state_nxt = deferred ? WAIT_SYNC : WR;
        else if (cmd_op == CMD_RD) state_nxt = RD;
        else begin
          invalid_cmd = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WR:        state_nxt = IDLE;
      WAIT_SYNC: if (frame_sync) state_nxt = WR;
      RD:        state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (reg_rd_valid) state_nxt = RESP;
        else if (tcnt == CW'(RD_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read timeout counter: cleared while the read strobe is out, counts RD_WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tcnt <= '0;
    else if (state == RD)       tcnt <= '0;
    else if (state == RD_WAIT)  tcnt <= tcnt + CW'(1);
  end

  // Bank and transmitter data registers; they hold their value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      txd_data  <= '0;
    end else begin
      if (state_nxt == WR || state_nxt == RD) reg_addr <= cmd_addr;
      if (state_nxt == WR) reg_wdata <= cmd_data;
      if (state == RD_WAIT && state_nxt == RESP)
        txd_data <= {CMD_RD, cmd_addr, 8'h00, reg_rd_valid ? reg_rdata : 32'hDEADBEEF};
    end
  end

  // Sticky error flags: a set event in the same cycle as clear_err keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_ovf <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      if (drop)           fifo_ovf <= 1'b1;
      else if (clear_err) fifo_ovf <= 1'b0;
      if (invalid_cmd || timeout) cmd_err <= 1'b1;
      else if (clear_err)         cmd_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_reg_sched.sv
// Testbench for spi_reg_sched: table of single-command vectors plus directed
// sequences for deferred writes, FIFO overflow, sticky-flag priority and reset.
module tb_spi_reg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd_flag = 1'b0;
  logic [63:0] rxd_data = '0;
  logic        frame_sync = 1'b0;
  logic        clear_err = 1'b0;
  logic        reg_wr_en, reg_rd_en, txd_load, busy, fifo_ovf, cmd_err;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = '0;
  logic        reg_rd_valid = 1'b0;
  logic [63:0] txd_data;

  int n_vec = 0;
  int n_err = 0;

  spi_reg_sched dut (
    .clk(clk), .rst_n(rst_n), .rxd_flag(rxd_flag), .rxd_data(rxd_data),
    .frame_sync(frame_sync), .clear_err(clear_err),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
    .txd_load(txd_load), .txd_data(txd_data), .busy(busy),
    .fifo_ovf(fifo_ovf), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] frame;
    int          rd_lat;      // cycles from reg_rd_en to reg_rd_valid, -1 = never
    logic [31:0] rdata;
    int          exp_wr_cyc;  // -1 = no write strobe expected
    logic [15:0] exp_addr;
    logic [31:0] exp_wdata;
    int          exp_rd_cyc;
    int          exp_txd_cyc;
    logic [63:0] exp_txd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  int          wr_n, wr_cyc, rd_n, rd_cyc, tx_n, tx_cyc;
  logic [15:0] waddr;
  logic [31:0] wdat;
  logic [63:0] txd_cap;
  logic [15:0] seq_addr [8];
  logic [31:0] seq_data [8];
  logic [15:0] a16;

  initial begin
    // frame, rd_lat, rdata, wr_cyc, addr, wdata, rd_cyc, txd_cyc, txd, err
    vt[0] = '{64'hA5_0010_00_12345678, -1, 32'h0, 3, 16'h0010, 32'h12345678, -1, -1, 64'h0, 1'b0};
    vt[1] = '{64'hA5_003F_00_0BADF00D, -1, 32'h0, 3, 16'h003F, 32'h0BADF00D, -1, -1, 64'h0, 1'b0};
    vt[2] = '{64'hA5_0070_00_00000070, -1, 32'h0, 3, 16'h0070, 32'h00000070, -1, -1, 64'h0, 1'b0};
    vt[3] = '{64'h5A_0020_FF_00000000, 3, 32'hCAFEF00D, -1, 16'h0, 32'h0, 3, 7, 64'h5A0020_00_CAFEF00D, 1'b0};
    vt[4] = '{64'h5A_0020_00_00000000, -1, 32'h0, -1, 16'h0, 32'h0, 3, 20, 64'h5A0020_00_DEADBEEF, 1'b1};
    vt[5] = '{64'h5A_0123_00_00000000, 16, 32'h55AA55AA, -1, 16'h0, 32'h0, 3, 20, 64'h5A0123_00_55AA55AA, 1'b0};
    vt[6] = '{64'h5A_0020_00_00000000, 17, 32'h12121212, -1, 16'h0, 32'h0, 3, 20, 64'h5A0020_00_DEADBEEF, 1'b1};
    vt[7] = '{64'h33_0010_00_00000001, -1, 32'h0, -1, 16'h0, 32'h0, -1, -1, 64'h0, 1'b1};
    vt[8] = '{64'hA4_0010_00_00000001, -1, 32'h0, -1, 16'h0, 32'h0, -1, -1, 64'h0, 1'b1};
    vt[9] = '{64'h5A_0001_00_00000000, 1, 32'h00000001, -1, 16'h0, 32'h0, 3, 5, 64'h5A0001_00_00000001, 1'b0};

    // Reset state
    #3;
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_txd_load", txd_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txd_data", txd_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table-driven single commands; cycle 0 is the cycle rxd_flag is high.
    for (int v = 0; v < NV; v++) begin
      do_clear();
      @(negedge clk);
      chk($sformatf("v%0d_err_cleared", v), cmd_err, 0);
      tick();
      rxd_flag = 1'b1;
      rxd_data = vt[v].frame;
      tick();
      rxd_flag = 1'b0;
      wr_n = 0; wr_cyc = -1; rd_n = 0; rd_cyc = -1; tx_n = 0; tx_cyc = -1;
      waddr = '0; wdat = '0; txd_cap = '0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (reg_wr_en) begin wr_n++; wr_cyc = c; waddr = reg_addr; wdat = reg_wdata; end
        if (reg_rd_en) begin rd_n++; rd_cyc = c; end
        if (txd_load)  begin tx_n++; tx_cyc = c; txd_cap = txd_data; end
        tick();
        reg_rd_valid = (rd_cyc >= 0) && (vt[v].rd_lat >= 0) && (c + 1 == rd_cyc + vt[v].rd_lat);
        reg_rdata    = reg_rd_valid ? vt[v].rdata : 32'h0;
      end
      reg_rd_valid = 1'b0;
      chk($sformatf("v%0d_wr_cnt", v), wr_n, (vt[v].exp_wr_cyc >= 0) ? 1 : 0);
      if (vt[v].exp_wr_cyc >= 0) begin
        chk($sformatf("v%0d_wr_cyc", v), wr_cyc, vt[v].exp_wr_cyc);
        chk($sformatf("v%0d_wr_addr", v), waddr, vt[v].exp_addr);
        chk($sformatf("v%0d_wr_data", v), wdat, vt[v].exp_wdata);
      end
      chk($sformatf("v%0d_rd_cnt", v), rd_n, (vt[v].exp_rd_cyc >= 0) ? 1 : 0);
      chk($sformatf("v%0d_rd_cyc", v), rd_cyc, vt[v].exp_rd_cyc);
      chk($sformatf("v%0d_txd_cnt", v), tx_n, (vt[v].exp_txd_cyc >= 0) ? 1 : 0);
      chk($sformatf("v%0d_txd_cyc", v), tx_cyc, vt[v].exp_txd_cyc);
      if (vt[v].exp_txd_cyc >= 0) chk($sformatf("v%0d_txd_data", v), txd_cap, vt[v].exp_txd);
      chk($sformatf("v%0d_cmd_err", v), cmd_err, vt[v].exp_err);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // Deferred write: frame_sync during DECODE is ignored, queued write waits behind it.
    do_clear();
    rxd_flag = 1'b1;
    rxd_data = 64'hA5_0045_00_0000ABCD;
    tick();
    rxd_data = 64'hA5_0011_00_11112222;
    tick();
    rxd_flag = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    wr_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (reg_wr_en) wr_n++;
      tick();
    end
    chk("defer_no_early_wr", wr_n, 0);
    chk("defer_busy", busy, 1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    @(negedge clk);
    chk("defer_wr_after_sync", reg_wr_en, 1);
    chk("defer_addr", reg_addr, 16'h0045);
    chk("defer_wdata", reg_wdata, 32'h0000ABCD);
    tick();
    wr_n = 0; wr_cyc = -1; waddr = '0; wdat = '0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (reg_wr_en) begin wr_n++; wr_cyc = c; waddr = reg_addr; wdat = reg_wdata; end
      tick();
    end
    chk("queued_wr_cnt", wr_n, 1);
    chk("queued_wr_cyc", wr_cyc, 4);
    chk("queued_wr_addr", waddr, 16'h0011);
    chk("queued_wr_data", wdat, 32'h11112222);
    chk("queued_busy_end", busy, 0);

    // Invalid command with clear_err in the same cycle as the error: set wins.
    do_clear();
    rxd_flag = 1'b1;
    rxd_data = 64'h33_0099_00_00000000;
    tick();
    rxd_flag = 1'b0;
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    chk("err_set_beats_clear", cmd_err, 1);
    tick();
    do_clear();
    @(negedge clk);
    chk("err_cleared", cmd_err, 0);
    tick();

    // Overflow while a deferred write is parked in WAIT_SYNC.
    rxd_flag = 1'b1;
    rxd_data = 64'hA5_0040_00_AAAA0000;
    tick();
    rxd_flag = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    chk("ovf_pre", fifo_ovf, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      a16 = 16'(i);
      rxd_flag = 1'b1;
      rxd_data = {8'hA5, a16, 8'h00, 16'hD000, a16};
      tick();
    end
    rxd_flag = 1'b0;
    @(negedge clk);
    chk("ovf_set", fifo_ovf, 1);
    chk("ovf_wr_held", reg_wr_en, 0);
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    wr_n = 0;
    for (int k = 0; k < 8; k++) begin seq_addr[k] = '0; seq_data[k] = '0; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (reg_wr_en) begin
        if (wr_n < 8) begin seq_addr[wr_n] = reg_addr; seq_data[wr_n] = reg_wdata; end
        wr_n++;
      end
      tick();
    end
    chk("ovf_wr_cnt", wr_n, 5);
    chk("ovf_addr0", seq_addr[0], 16'h0040);
    chk("ovf_data0", seq_data[0], 32'hAAAA0000);
    for (int k = 1; k < 5; k++) begin
      a16 = 16'(k);
      chk($sformatf("ovf_addr%0d", k), seq_addr[k], a16);
      chk($sformatf("ovf_data%0d", k), seq_data[k], {16'hD000, a16});
    end
    chk("ovf_sticky", fifo_ovf, 1);

    // Reset while a deferred write waits: everything returns to zero, no write afterwards.
    rxd_flag = 1'b1;
    rxd_data = 64'h77_0000_00_00000000;
    tick();
    rxd_flag = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rxd_flag = 1'b1;
    rxd_data = 64'hA5_006F_00_DEAD0001;
    tick();
    rxd_flag = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_err", cmd_err, 1);
    chk("pre_rst_no_wr", reg_wr_en, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", reg_wr_en, 0);
    chk("arst_rd_en", reg_rd_en, 0);
    chk("arst_addr", reg_addr, 0);
    chk("arst_wdata", reg_wdata, 0);
    chk("arst_txd_load", txd_load, 0);
    chk("arst_txd_data", txd_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovf", fifo_ovf, 0);
    chk("arst_err", cmd_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    wr_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (reg_wr_en) wr_n++;
      tick();
    end
    chk("post_rst_no_wr", wr_n, 0);
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
